alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer_if.sv | 39 +++
 rtl/alu_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request/ALU-control bundle for alu_sequencer.
// Ports: req_* handshake, alu_* control/status, opnd_hi, res_we, done, flags.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic        req_wide;
  logic        req_use_carry;
  logic [4:0]  alu_f;
  logic        alu_csel;
  logic        alu_ucin;
  logic        alu_srcin;
  logic        alu_notALUOE;
  logic        alu_notShiftOE;
  logic [15:0] alu_y;
  logic        alu_cout;
  logic        alu_zout;
  logic        opnd_hi;
  logic        res_we;
  logic        done;
  logic        flag_c;
  logic        flag_z;

  modport slave (
    input  req_valid, req_op, req_wide, req_use_carry,
    input  alu_y, alu_cout, alu_zout,
    output req_ready, alu_f, alu_csel, alu_ucin, alu_srcin,
    output alu_notALUOE, alu_notShiftOE,
    output opnd_hi, res_we, done, flag_c, flag_z
  );

  modport master (
    output req_valid, req_op, req_wide, req_use_carry,
    output alu_y, alu_cout, alu_zout,
    input  req_ready, alu_f, alu_csel, alu_ucin, alu_srcin,
    input  alu_notALUOE, alu_notShiftOE,
    input  opnd_hi, res_we, done, flag_c, flag_z
  );
endinterface

// File: rtl/alu_sequencer.sv
// Control FSM for the 16-bit ALU/shifter: one op per handshake, 32-bit via two passes.
// Ports: clock, reset (async, active-high), bus (alu_sequencer_if.slave).
module alu_sequencer (
  input  logic               clock,
  input  logic               reset,
  alu_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic        wide_q, wide_d;
  logic        uc_q, uc_d;
  logic        zlo_q, zlo_d;
  logic        fc_q, fc_d;
  logic        fz_q, fz_d;

  logic [4:0]  f_q, f_d;
  logic        csel_q, csel_d;
  logic        ucin_q, ucin_d;
  logic        srcin_q, srcin_d;
  logic        naoe_q, naoe_d;
  logic        nsoe_q, nsoe_d;
  logic        hi_q, hi_d;
  logic        we_q, we_d;
  logic        done_q, done_d;
  logic        rdy_q, rdy_d;

  function automatic logic [4:0] f_of(input logic [3:0] op);
    logic [4:0] f;
    f = 5'b00000;
    unique case (op)
      4'd0:    f = 5'b10010;
      4'd1:    f = 5'b01100;
      4'd2:    f = 5'b10111;
      4'd3:    f = 5'b11101;
      4'd4:    f = 5'b01101;
      4'd5:    f = 5'b00001;
      4'd6:    f = 5'b11111;
      4'd7:    f = 5'b00101;
      4'd8:    f = 5'b00010;
      default: f = 5'b00000;
    endcase
    return f;
  endfunction

  logic cur_arith, cur_shift, cur_nop;
  logic nxt_arith, nxt_alu, nxt_shift, nxt_nop;

  assign cur_arith = (op_q <= 4'd1);
  assign cur_shift = (op_q == 4'd7) || (op_q == 4'd8);
  assign cur_nop   = (op_q > 4'd8);
  assign nxt_arith = (op_d <= 4'd1);
  assign nxt_alu   = (op_d <= 4'd6);
  assign nxt_shift = (op_d == 4'd7) || (op_d == 4'd8);
  assign nxt_nop   = (op_d > 4'd8);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wide_d  = wide_q;
    uc_d    = uc_q;
    zlo_d   = zlo_q;
    fc_d    = fc_q;
    fz_d    = fz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = LO;
          op_d    = bus.req_op;
          wide_d  = bus.req_wide;
          uc_d    = bus.req_use_carry;
        end
      end
      LO: begin
        zlo_d = bus.alu_zout;
        if (wide_q && (op_q <= 4'd6)) begin
          state_d = HI;
        end else begin
          state_d = DONE;
          if (!cur_nop)
            fz_d = bus.alu_zout;
          if (cur_arith || cur_shift)
            fc_d = bus.alu_cout;
        end
      end
      HI: begin
        state_d = DONE;
        fz_d    = zlo_q & bus.alu_zout;
        if (cur_arith)
          fc_d = bus.alu_cout;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are
  // registered and stable for the whole LO/HI cycle.
  always_comb begin
    f_d     = 5'b00000;
    csel_d  = 1'b0;
    ucin_d  = 1'b0;
    srcin_d = 1'b0;
    naoe_d  = 1'b1;
    nsoe_d  = 1'b1;
    hi_d    = 1'b0;
    we_d    = 1'b0;
    done_d  = 1'b0;
    rdy_d   = 1'b0;

    unique case (state_d)
      IDLE: rdy_d = 1'b1;
      LO: begin
        f_d    = f_of(op_d);
        naoe_d = !nxt_alu;
        nsoe_d = !nxt_shift;
        ucin_d = (op_d == 4'd1);
        we_d   = !nxt_nop;
        if (nxt_arith && uc_d) begin
          csel_d  = 1'b1;
          srcin_d = fc_q;
        end
      end
      HI: begin
        f_d    = f_of(op_d);
        naoe_d = 1'b0;
        ucin_d = (op_d == 4'd1);
        hi_d   = 1'b1;
        we_d   = 1'b1;
        // Chain the low-word carry sampled at the end of LO.
        if (nxt_arith) begin
          csel_d  = 1'b1;
          srcin_d = bus.alu_cout;
        end
      end
      DONE: done_d = 1'b1;
      default: rdy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 4'd0;
      wide_q  <= 1'b0;
      uc_q    <= 1'b0;
      zlo_q   <= 1'b0;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
      f_q     <= 5'b00000;
      csel_q  <= 1'b0;
      ucin_q  <= 1'b0;
      srcin_q <= 1'b0;
      naoe_q  <= 1'b1;
      nsoe_q  <= 1'b1;
      hi_q    <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wide_q  <= wide_d;
      uc_q    <= uc_d;
      zlo_q   <= zlo_d;
      fc_q    <= fc_d;
      fz_q    <= fz_d;
      f_q     <= f_d;
      csel_q  <= csel_d;
      ucin_q  <= ucin_d;
      srcin_q <= srcin_d;
      naoe_q  <= naoe_d;
      nsoe_q  <= nsoe_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.req_ready      = rdy_q;
  assign bus.alu_f          = f_q;
  assign bus.alu_csel       = csel_q;
  assign bus.alu_ucin       = ucin_q;
  assign bus.alu_srcin      = srcin_q;
  assign bus.alu_notALUOE   = naoe_q;
  assign bus.alu_notShiftOE = nsoe_q;
  assign bus.opnd_hi        = hi_q;
  assign bus.res_we         = we_q;
  assign bus.done           = done_q;
  assign bus.flag_c         = fc_q;
  assign bus.flag_z         = fz_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer with a behavioural ALU and result scoreboard.
// Ports: none.
module tb_alu_sequencer;
  logic clock;
  logic reset;
  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [15:0] a_lo, b_lo, a_hi, b_hi;
  logic [16:0] sb [$];

  logic [4:0] f_lo;
  logic       csel_lo, srcin_lo, ucin_lo, naoe_lo, nsoe_lo, we_lo;
  logic       csel_hi, srcin_hi, we_hi;
  int         done_cyc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural 74181/shifter pair.
  logic [15:0] ma, mb;
  logic        mcin;
  logic [16:0] r;
  always_comb begin
    ma   = bus.opnd_hi ? a_hi : a_lo;
    mb   = bus.opnd_hi ? b_hi : b_lo;
    mcin = bus.alu_csel ? bus.alu_srcin : bus.alu_ucin;
    r    = 17'd0;
    case (bus.alu_f)
      5'b10010: r = {1'b0, ma} + {1'b0, mb} + {16'd0, mcin};
      5'b01100: r = {1'b0, ma} + {1'b0, ~mb} + {16'd0, mcin};
      5'b10111: r = {1'b0, ma & mb};
      5'b11101: r = {1'b0, ma | mb};
      5'b01101: r = {1'b0, ma ^ mb};
      5'b00001: r = {1'b0, ~ma};
      5'b11111: r = {1'b0, ma};
      5'b00101: r = {ma[15], ma[14:0], 1'b0};
      5'b00010: r = {ma[0], 1'b0, ma[15:1]};
      default:  r = 17'd0;
    endcase
    if (bus.alu_notALUOE && bus.alu_notShiftOE)
      r = 17'd0;
    bus.alu_y    = r[15:0];
    bus.alu_cout = r[16];
    bus.alu_zout = (r[15:0] == 16'd0);
  end

  // Scoreboard: each res_we pops one expected {opnd_hi, result}.
  always @(negedge clock) begin
    if (!reset) begin
      chk("oe_exclusive",
          {31'd0, !(!bus.alu_notALUOE && !bus.alu_notShiftOE)}, 32'd1);
      if (bus.res_we) begin
        if (sb.size() == 0) begin
          chk("unexpected_res_we", 32'd1, 32'd0);
        end else begin
          logic [16:0] e;
          e = sb.pop_front();
          chk("result", {15'd0, bus.opnd_hi, bus.alu_y}, {15'd0, e});
        end
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic wide,
                       input logic uc, input logic [15:0] al,
                       input logic [15:0] bl, input logic [15:0] ah,
                       input logic [15:0] bh, input int nwe,
                       input logic [15:0] el, input logic [15:0] eh);
    a_lo = al; b_lo = bl; a_hi = ah; b_hi = bh;
    if (nwe > 0) sb.push_back({1'b0, el});
    if (nwe > 1) sb.push_back({1'b1, eh});
    @(negedge clock);
    chk("ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid     = 1'b1;
    bus.req_op        = op;
    bus.req_wide      = wide;
    bus.req_use_carry = uc;
    @(posedge clock);
    #1;
    bus.req_valid     = 1'b0;
    bus.req_op        = ~op;
    bus.req_wide      = ~wide;
    bus.req_use_carry = ~uc;
    done_cyc = 0;
    for (int n = 1; n <= 8 && done_cyc == 0; n++) begin
      @(negedge clock);
      if (n == 1) begin
        f_lo = bus.alu_f; csel_lo = bus.alu_csel;
        srcin_lo = bus.alu_srcin; ucin_lo = bus.alu_ucin;
        naoe_lo = bus.alu_notALUOE; nsoe_lo = bus.alu_notShiftOE;
        we_lo = bus.res_we;
      end
      if (n == 2) begin
        csel_hi = bus.alu_csel; srcin_hi = bus.alu_srcin;
        we_hi = bus.res_we;
      end
      if (bus.done) done_cyc = n;
    end
    chk("done_cycle", done_cyc, (nwe > 1) ? 32'd3 : 32'd2);
    @(negedge clock);
    chk("ready_after", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    logic [3:0]  tops [4];
    logic [4:0]  tf   [4];
    logic [15:0] tres [4];
    bus.req_valid = 1'b0;
    bus.req_op = 4'd0;
    bus.req_wide = 1'b0;
    bus.req_use_carry = 1'b0;
    a_lo = 0; b_lo = 0; a_hi = 0; b_hi = 0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_oe", {30'd0, bus.alu_notALUOE, bus.alu_notShiftOE}, 32'd3);
    chk("rst_f", {27'd0, bus.alu_f}, 32'd0);
    chk("rst_ctl", {26'd0, bus.alu_csel, bus.alu_ucin, bus.alu_srcin,
        bus.opnd_hi, bus.res_we, bus.done}, 32'd0);
    chk("rst_flags", {30'd0, bus.flag_c, bus.flag_z}, 32'd0);
    #2 reset = 1'b0;

    // ADD 1+1
    do_op(4'd0, 0, 0, 16'h0001, 16'h0001, 0, 0, 1, 16'h0002, 0);
    chk("add_f", {27'd0, f_lo}, 32'b10010);
    chk("add_we", {31'd0, we_lo}, 32'd1);
    chk("add_flags", {30'd0, bus.flag_c, bus.flag_z}, 32'd0);

    // Wide ADD FFFF+1 carries into the high word
    do_op(4'd0, 1, 0, 16'hFFFF, 16'h0001, 0, 0, 2, 16'h0000, 16'h0001);
    chk("wadd_hi_carry", {30'd0, csel_hi, srcin_hi}, 32'd3);
    chk("wadd_hi_we", {31'd0, we_hi}, 32'd1);
    chk("wadd_flags", {30'd0, bus.flag_c, bus.flag_z}, 32'd0);

    // SUB equal operands
    do_op(4'd1, 0, 0, 16'h1234, 16'h1234, 0, 0, 1, 16'h0000, 0);
    chk("sub_ucin", {30'd0, ucin_lo, csel_lo}, 32'd2);
    chk("sub_flags", {30'd0, bus.flag_c, bus.flag_z}, 32'd3);

    // SBC 0-1 with stored carry
    do_op(4'd1, 0, 1, 16'h0000, 16'h0001, 0, 0, 1, 16'hFFFF, 0);
    chk("sbc_carry", {30'd0, csel_lo, srcin_lo}, 32'd3);
    chk("sbc_flags", {30'd0, bus.flag_c, bus.flag_z}, 32'd0);

    // SHL, wide request must run single-pass
    do_op(4'd7, 1, 0, 16'h8001, 0, 0, 0, 1, 16'h0002, 0);
    chk("shl_oe", {30'd0, naoe_lo, nsoe_lo}, 32'd2);
    chk("shl_flags", {30'd0, bus.flag_c, bus.flag_z}, 32'd2);

    // SHR
    do_op(4'd8, 0, 0, 16'h0001, 0, 0, 0, 1, 16'h0000, 0);
    chk("shr_f", {27'd0, f_lo}, 32'b00010);
    chk("shr_flags", {30'd0, bus.flag_c, bus.flag_z}, 32'd3);

    // AND with carry preset; use_carry ignored
    do_op(4'd2, 0, 1, 16'hF0F0, 16'h0F0F, 0, 0, 1, 16'h0000, 0);
    chk("and_csel", {31'd0, csel_lo}, 32'd0);
    chk("and_flags", {30'd0, bus.flag_c, bus.flag_z}, 32'd3);

    // NOP op 12
    do_op(4'd12, 0, 0, 16'h1111, 16'h2222, 0, 0, 0, 0, 0);
    chk("nop_oe", {30'd0, naoe_lo, nsoe_lo}, 32'd3);
    chk("nop_we", {31'd0, we_lo}, 32'd0);
    chk("nop_flags", {30'd0, bus.flag_c, bus.flag_z}, 32'd3);

    // Remaining logic ops
    tops[0] = 4'd3; tf[0] = 5'b11101; tres[0] = 16'hFFF0;
    tops[1] = 4'd4; tf[1] = 5'b01101; tres[1] = 16'hF0F0;
    tops[2] = 4'd5; tf[2] = 5'b00001; tres[2] = 16'h00FF;
    tops[3] = 4'd6; tf[3] = 5'b11111; tres[3] = 16'hFF00;
    for (int i = 0; i < 4; i++) begin
      do_op(tops[i], 0, 0, 16'hFF00, 16'h0FF0, 0, 0, 1, tres[i], 0);
      chk("logic_f", {27'd0, f_lo}, {27'd0, tf[i]});
    end
    chk("logic_flag_c", {31'd0, bus.flag_c}, 32'd1);

    // Wide logic op: XOR on both words, zero only if both are zero
    do_op(4'd4, 1, 0, 16'h00FF, 16'h00FF, 16'h1000, 16'h0000,
          2, 16'h0000, 16'h1000);
    chk("wxor_flags", {30'd0, bus.flag_c, bus.flag_z}, 32'd2);

    // Reset during the HI cycle of a wide ADD
    a_lo = 16'hFFFF; b_lo = 16'h0001; a_hi = 0; b_hi = 0;
    sb.push_back({1'b0, 16'h0000});
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_op = 4'd0;
    bus.req_wide = 1'b1; bus.req_use_carry = 1'b0;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_oe", {30'd0, bus.alu_notALUOE, bus.alu_notShiftOE}, 32'd3);
    chk("mid_rst_we", {31'd0, bus.res_we}, 32'd0);
    chk("mid_rst_flags", {30'd0, bus.flag_c, bus.flag_z}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clock);
    #2 reset = 1'b0;

    // Resumes in IDLE
    do_op(4'd0, 0, 0, 16'h0002, 16'h0003, 0, 0, 1, 16'h0005, 0);
    chk("post_rst_flags", {30'd0, bus.flag_c, bus.flag_z}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
